// File: rtl/bpsk_pkg.sv
// Shared definitions for the UART-to-BPSK framing path: sync marker,
// frame controller states and error cause encodings.
package bpsk_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Payload length field width; also sets pkt_len and index widths.
    localparam int LEN_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_SEND    = 3'd4
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_SUM     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/packet_ram.sv
// Payload storage: single synchronous write port, asynchronous read port.
module packet_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/packet_buffer_ctrl.sv
// Frame receiver: collects SYNC/LEN/payload/checksum bytes from a UART
// deserializer, verifies them and streams the payload toward the modulator.
module packet_buffer_ctrl
    import bpsk_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_word,
    input  logic       uart_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    output logic [4:0] pkt_len,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // tx handshake: a byte transfers on a rising clk edge where tx_valid and
    // tx_ready are both high; tx_data/tx_last hold while tx_valid & !tx_ready.

    state_e           state;
    logic             sync_ff1;
    logic             sync_ff2;
    logic             ready_prev;
    logic             byte_stb;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] rd_idx;
    logic [7:0]       sum;
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_frame;
    logic             tmo_hit;
    logic             err_pulse_q;
    logic [1:0]       err_code_q;
    logic             wr_en;
    logic [7:0]       rd_data;
    logic             last_byte;

    assign byte_stb  = sync_ff2 & ~ready_prev;
    assign in_frame  = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);
    assign tmo_hit   = in_frame && !byte_stb && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign wr_en     = (state == ST_PAYLOAD) && byte_stb;
    assign last_byte = (rd_idx == len - LEN_W'(1));

    packet_ram #(
        .DEPTH (MAX_LEN),
        .ADDR_W(AW)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(idx[AW-1:0]),
        .wr_data(uart_word),
        .rd_addr(rd_idx[AW-1:0]),
        .rd_data(rd_data)
    );

    // Inter-byte gap counter; only meaningful while a frame is being received.
    always_ff @(posedge clk) begin
        if (rst || !in_frame || byte_stb) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sync_ff1    <= 1'b0;
            sync_ff2    <= 1'b0;
            ready_prev  <= 1'b0;
            len         <= '0;
            idx         <= '0;
            rd_idx      <= '0;
            sum         <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            sync_ff1    <= uart_ready;
            sync_ff2    <= sync_ff1;
            ready_prev  <= sync_ff2;
            err_pulse_q <= 1'b0;
            if (tmo_hit) begin
                state       <= ST_IDLE;
                err_pulse_q <= 1'b1;
                err_code_q  <= ERR_TIMEOUT;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (byte_stb && uart_word == SYNC_BYTE) begin
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (byte_stb) begin
                            if (uart_word == 8'd0 || uart_word > 8'(MAX_LEN)) begin
                                state       <= ST_IDLE;
                                err_pulse_q <= 1'b1;
                                err_code_q  <= ERR_LEN;
                            end else begin
                                len   <= uart_word[LEN_W-1:0];
                                sum   <= '0;
                                idx   <= '0;
                                state <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (byte_stb) begin
                            sum <= sum + uart_word;
                            idx <= idx + LEN_W'(1);
                            if (idx == len - LEN_W'(1)) begin
                                state <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (byte_stb) begin
                            if (uart_word == sum) begin
                                rd_idx <= '0;
                                state  <= ST_SEND;
                            end else begin
                                state       <= ST_IDLE;
                                err_pulse_q <= 1'b1;
                                err_code_q  <= ERR_SUM;
                            end
                        end
                    end
                    ST_SEND: begin
                        // Incoming bytes are dropped here; only the handshake moves us.
                        if (tx_ready) begin
                            if (last_byte) begin
                                state <= ST_IDLE;
                            end else begin
                                rd_idx <= rd_idx + LEN_W'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign tx_valid  = (state == ST_SEND);
    assign tx_data   = tx_valid ? rd_data : 8'h00;
    assign tx_last   = tx_valid && last_byte;
    assign pkt_len   = (state == ST_PAYLOAD || state == ST_CHECK || state == ST_SEND) ? len : 5'd0;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_packet_buffer_ctrl.sv
// Bench for packet_buffer_ctrl: drives UART-level frames, scoreboards the
// tx stream and error strobes against expectations built from the frames.
module tb_packet_buffer_ctrl;
    import bpsk_pkg::*;

    localparam int TMO  = 40;
    localparam int MAXL = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] uart_word;
    logic       uart_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic [4:0] pkt_len;
    logic       err_pulse;
    logic [1:0] err_code;
    logic       busy;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    packet_buffer_ctrl #(
        .SYNC_BYTE     (8'hA5),
        .MAX_LEN       (MAXL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_word (uart_word),
        .uart_ready(uart_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last),
        .pkt_len   (pkt_len),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] exp_q[$];
    logic [1:0] err_q[$];
    logic [4:0] exp_len  = '0;
    int         hs_cnt   = 0;
    int         cyc      = 0;
    int         first_hs = 0;
    int         last_hs  = 0;
    int         raise_cyc = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out   = '0;
    logic [7:0] pl [MAXL];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_word  = b;
        uart_ready = 1'b1;
        ticks(4);
        uart_ready = 1'b0;
        ticks(3);
    endtask

    task automatic send_frame(input int n, input bit corrupt, input logic [7:0] bad_byte);
        logic [7:0] s;
        s = 8'h00;
        exp_len = 5'(n);
        for (int i = 0; i < n; i++) begin
            s = s + pl[i];
            if (!corrupt) exp_q.push_back({(i == n - 1), pl[i]});
        end
        if (corrupt) err_q.push_back(ERR_SUM);
        send_byte(8'hA5);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) send_byte(pl[i]);
        raise_cyc = cyc;
        send_byte(corrupt ? bad_byte : s);
    endtask

    task automatic check_outputs_idle(input string tag, input logic [1:0] code);
        check_val({tag, "_tx_valid"}, tx_valid, 0);
        check_val({tag, "_tx_last"}, tx_last, 0);
        check_val({tag, "_tx_data"}, tx_data, 0);
        check_val({tag, "_pkt_len"}, pkt_len, 0);
        check_val({tag, "_err_pulse"}, err_pulse, 0);
        check_val({tag, "_err_code"}, err_code, code);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_state"}, state_dbg, ST_IDLE);
    endtask

    // Monitor: sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        logic [8:0] e;
        logic [1:0] ec;
        cyc++;
        if (prev_stall && tx_valid) check_val("stall_hold", {tx_last, tx_data}, prev_out);
        if (tx_valid && tx_ready) begin
            check_val("tx_expected_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("tx_byte", {tx_last, tx_data}, e);
                check_val("tx_pkt_len", pkt_len, exp_len);
            end
            hs_cnt++;
            if (hs_cnt == 1) first_hs = cyc;
            last_hs = cyc;
        end
        if (err_pulse) begin
            check_val("err_expected_pending", 32'(err_q.size() != 0), 1);
            if (err_q.size() != 0) begin
                ec = err_q.pop_front();
                check_val("err_code", err_code, ec);
            end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_out   = {tx_last, tx_data};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;

        rst        = 1'b1;
        uart_ready = 1'b0;
        uart_word  = 8'h00;
        tx_ready   = 1'b1;
        ticks(3);
        check_outputs_idle("reset", ERR_NONE);
        rst = 1'b0;
        ticks(2);

        // Basic frame, tx_ready held high.
        pl[0] = 8'h10; pl[1] = 8'h20; pl[2] = 8'h30;
        hs_cnt = 0;
        send_frame(3, 1'b0, 8'h00);
        ticks(3);
        check_val("a_handshakes", hs_cnt, 3);
        check_val("a_back_to_back", last_hs - first_hs, 2);
        check_val("a_first_tx_latency", first_hs - raise_cyc, 4);
        check_outputs_idle("a_after", ERR_NONE);

        // Checksum error.
        pl[0] = 8'h01; pl[1] = 8'h02;
        hs_cnt = 0;
        send_frame(2, 1'b1, 8'hFF);
        ticks(3);
        check_val("b_handshakes", hs_cnt, 0);
        check_outputs_idle("b_after", ERR_SUM);

        // Bad lengths and a stray non-sync byte.
        err_q.push_back(ERR_LEN);
        send_byte(8'hA5);
        send_byte(8'h00);
        check_outputs_idle("len0", ERR_LEN);
        err_q.push_back(ERR_LEN);
        send_byte(8'hA5);
        send_byte(8'h11);
        check_outputs_idle("len17", ERR_LEN);
        send_byte(8'h3C);
        check_val("stray_busy", busy, 0);

        // Boundary lengths: MAX_LEN and 1.
        for (int i = 0; i < MAXL; i++) pl[i] = 8'($urandom_range(0, 255));
        hs_cnt = 0;
        send_frame(MAXL, 1'b0, 8'h00);
        ticks(MAXL + 3);
        check_val("max_handshakes", hs_cnt, MAXL);
        check_val("max_back_to_back", last_hs - first_hs, MAXL - 1);
        pl[0] = 8'($urandom_range(0, 255));
        hs_cnt = 0;
        send_frame(1, 1'b0, 8'h00);
        ticks(3);
        check_val("one_handshakes", hs_cnt, 1);

        // Inter-byte timeout inside a frame.
        err_q.push_back(ERR_TIMEOUT);
        send_byte(8'hA5);
        send_byte(8'h04);
        uart_word  = 8'h01;
        uart_ready = 1'b1;
        n = 0;
        found = 1'b0;
        while (n < TMO + 20 && !found) begin
            tick();
            n++;
            if (n == 4) uart_ready = 1'b0;
            if (err_pulse) found = 1'b1;
        end
        check_val("timeout_cycles", n, TMO + 3);
        ticks(2);
        check_outputs_idle("timeout_after", ERR_TIMEOUT);
        for (int i = 0; i < 2; i++) pl[i] = 8'($urandom_range(0, 255));
        hs_cnt = 0;
        send_frame(2, 1'b0, 8'h00);
        ticks(3);
        check_val("post_timeout_handshakes", hs_cnt, 2);

        // Back-pressure with a byte arriving during SEND.
        pl[0] = 8'h33; pl[1] = 8'h44;
        tx_ready = 1'b0;
        hs_cnt = 0;
        send_frame(2, 1'b0, 8'h00);
        check_val("stall_valid", tx_valid, 1);
        check_val("stall_pkt_len", pkt_len, 2);
        fork
            begin
                tx_ready = 1'b1; tick();
                tx_ready = 1'b0; tick(); tick();
                tx_ready = 1'b1; tick();
                tick();
            end
            send_byte(8'hA5);
        join
        tx_ready = 1'b1;
        ticks(2);
        check_val("stall_handshakes", hs_cnt, 2);
        check_outputs_idle("stall_after", ERR_TIMEOUT);

        // Reset mid-frame.
        for (int i = 0; i < 4; i++) pl[i] = 8'($urandom_range(0, 255));
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(pl[0]);
        send_byte(pl[1]);
        check_val("pre_rst_pkt_len", pkt_len, 4);
        rst = 1'b1;
        tick();
        check_outputs_idle("midrst", ERR_NONE);
        rst = 1'b0;
        tick();
        hs_cnt = 0;
        send_frame(4, 1'b0, 8'h00);
        ticks(4);
        check_val("post_rst_handshakes", hs_cnt, 4);

        ticks(5);
        check_val("tx_queue_drained", exp_q.size(), 0);
        check_val("err_queue_drained", err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
